// File: rtl/io_seq_pkg.sv
// Shared types and default sizes for the IO sequence checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_TMO_W = 16;

endpackage

// File: rtl/io_seq_sync.sv
// Capture chain that brings io_in into the wb_clk_i domain (1 or 2 flops).
// Latency: STAGES cycles from io_in to q.
// Backpressure: none, free-running every cycle.
module io_seq_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // Shift the pad value through the capture stages.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/io_seq_checker.sv
// Ordered masked-pattern sequence monitor on io_in with per-step timeout.
// Latency: io_in to pass 3 cycles with IO_SEQ_SYNC_EN defined, 2 cycles without.
// Backpressure: ld_ready low outside IDLE or when the pattern memory is full.
module io_seq_checker
  import io_seq_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int TMO_W = DEF_TMO_W,
  localparam int IDX_W = $clog2(DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] io_in,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [WIDTH-1:0] mask,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             start,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] cur_idx,
  output logic [IDX_W-1:0] fail_idx,
  output logic [IDX_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

`ifdef IO_SEQ_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] io_s;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mask_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] timer_q;
  logic             ld_acc;
  logic             start_go;
  logic [IDX_W-1:0] cnt_run;
  logic             match;
  logic             last_ent;
  logic             expire;

  io_seq_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .d        (io_in),
    .q        (io_s)
  );

  // clr outranks loads; a load coinciding with start is counted into the run.
  assign ld_acc   = ld_valid & ld_ready & ~clr;
  assign start_go = start & (state_q != ST_RUN);
  assign cnt_run  = count + IDX_W'(ld_acc);
  // cur_idx < count <= DEPTH while in RUN, so the low bits address the entry.
  assign match    = ((io_s ^ mem[cur_idx[AW-1:0]]) & mask_q) == '0;
  assign last_ent = (cur_idx + IDX_W'(1)) == count;
  assign expire   = (tmo_q != '0) && (timer_q == tmo_q - TMO_W'(1));

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: a match on the final entry beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (match && last_ent)  state_d = ST_PASS;
          else if (!match && expire) state_d = ST_FAIL;
        end
        default: begin
          if (start) state_d = (cnt_run == '0) ? ST_PASS : ST_RUN;
        end
      endcase
    end
  end

  // Status outputs decoded from registered state and count.
  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_PASS) || (state_q == ST_FAIL);
    pass     = (state_q == ST_PASS);
    ld_ready = (state_q == ST_IDLE) && (count < IDX_W'(DEPTH));
  end

  // Step index, timeout timer, failure index and latched run configuration.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count    <= '0;
      cur_idx  <= '0;
      fail_idx <= '0;
      timer_q  <= '0;
      mask_q   <= '0;
      tmo_q    <= '0;
    end else if (clr) begin
      count    <= '0;
      cur_idx  <= '0;
      fail_idx <= '0;
      timer_q  <= '0;
    end else begin
      if (ld_acc) count <= count + IDX_W'(1);
      if (start_go) begin
        cur_idx <= '0;
        timer_q <= '0;
        mask_q  <= mask;
        tmo_q   <= tmo_limit;
      end else if (state_q == ST_RUN) begin
        if (match) begin
          cur_idx <= cur_idx + IDX_W'(1);
          timer_q <= '0;
        end else if (expire) begin
          fail_idx <= cur_idx;
        end else begin
          timer_q <= timer_q + TMO_W'(1);
        end
      end
    end
  end

  // Pattern memory; contents are meaningless beyond count, so no reset.
  always_ff @(posedge wb_clk_i) begin
    if (ld_acc) mem[count[AW-1:0]] <= ld_data;
  end

endmodule
